alarm_display_sched: RTL and testbench

//  Scan/blink controller for the alarm clock's 4-digit 7-segment display.

---
 rtl/alarm_display_sched.sv | 114 +++++++++++
 tb/tb_alarm_display_sched.sv | 130 +++++++++++++
 2 files changed

// File: rtl/alarm_display_sched.sv
// Display scan and blink controller for the alarm clock's 4-digit 7-segment display.
// One segment bus is time-shared across the digits; an alarm shows a blinking "UPUP" message.
module alarm_display_sched #(
  parameter int SCAN_DIV      = 4,
  parameter int BLINK_DIV     = 8,
  parameter int ALARM_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [27:0] time_segs,
  input  logic        alarm_req,
  input  logic        dismiss,
  output logic [6:0]  seg,
  output logic [3:0]  digit_en,
  output logic        alarm_active
);
  // state     | meaning
  // NORMAL    | time patterns scanned out
  // ALARM_ON  | "UPUP" message lit
  // ALARM_OFF | blank half of the blink
  typedef enum logic [1:0] {NORMAL, ALARM_ON, ALARM_OFF} state_t;

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int PW = (ALARM_TIMEOUT > 1) ? $clog2(ALARM_TIMEOUT) : 1;
  localparam logic [6:0] SEG_U = 7'b0111110;
  localparam logic [6:0] SEG_P = 7'b1100111;

  state_t        state, state_nxt;
  logic [SW-1:0] scan_cnt;
  logic [1:0]    idx;
  logic [BW-1:0] blink_cnt, blink_nxt;
  logic [PW-1:0] pair_cnt, pair_nxt;
  logic [6:0]    seg_nxt;
  logic          blink_tc;

  assign blink_tc = (blink_cnt == BW'(BLINK_DIV - 1));

  always_comb begin
    state_nxt = state;
    blink_nxt = blink_cnt;
    pair_nxt  = pair_cnt;
    case (state)
      NORMAL: begin
        if (alarm_req && !dismiss) begin
          state_nxt = ALARM_ON;
          blink_nxt = '0;
          pair_nxt  = '0;
        end
      end
      ALARM_ON, ALARM_OFF: begin
        if (dismiss) begin
          state_nxt = NORMAL;
          blink_nxt = '0;
          pair_nxt  = '0;
        end else if (alarm_req) begin
          state_nxt = ALARM_ON;
          blink_nxt = '0;
          pair_nxt  = '0;
        end else if (blink_tc) begin
          blink_nxt = '0;
          if (state == ALARM_ON) begin
            state_nxt = ALARM_OFF;
          end else if (pair_cnt == PW'(ALARM_TIMEOUT - 1)) begin
            state_nxt = NORMAL;
            pair_nxt  = '0;
          end else begin
            state_nxt = ALARM_ON;
            pair_nxt  = pair_cnt + PW'(1);
          end
        end else begin
          blink_nxt = blink_cnt + BW'(1);
        end
      end
      default: state_nxt = NORMAL;
    endcase
  end

  // Pattern follows the state being entered so seg and alarm_active switch on the same edge.
  always_comb begin
    seg_nxt = 7'b0000000;
    case (state_nxt)
      NORMAL:   seg_nxt = time_segs[7*idx +: 7];
      ALARM_ON: seg_nxt = idx[0] ? SEG_U : SEG_P;
      default:  seg_nxt = 7'b0000000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= NORMAL;
      scan_cnt     <= '0;
      idx          <= 2'd0;
      blink_cnt    <= '0;
      pair_cnt     <= '0;
      seg          <= 7'b0000000;
      digit_en     <= 4'b0001;
      alarm_active <= 1'b0;
    end else begin
      state     <= state_nxt;
      blink_cnt <= blink_nxt;
      pair_cnt  <= pair_nxt;
      if (scan_cnt == SW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        idx      <= idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end
      seg          <= seg_nxt;
      digit_en     <= 4'b0001 << idx;
      alarm_active <= (state_nxt != NORMAL);
    end
  end
endmodule

// File: tb/tb_alarm_display_sched.sv
// Randomized bench for alarm_display_sched against an elapsed-time reference model.
// The model tracks cycles since reset and since alarm entry rather than FSM states.
module tb_alarm_display_sched;
  localparam int SCAN_DIV = 4;
  localparam int BLINK_DIV = 8;
  localparam int ALARM_TIMEOUT = 4;
  localparam int ALARM_LEN = 2 * BLINK_DIV * ALARM_TIMEOUT;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [27:0] time_segs = 28'h0_1234567;
  logic        alarm_req = 1'b0;
  logic        dismiss = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  digit_en;
  logic        alarm_active;

  int checks = 0;
  int errors = 0;

  // reference model state
  int   t_edges;
  bit   in_alarm;
  int   elapsed;
  logic [6:0] exp_seg;
  logic [3:0] exp_de;
  logic       exp_aa;

  alarm_display_sched #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV), .ALARM_TIMEOUT(ALARM_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .time_segs(time_segs), .alarm_req(alarm_req),
    .dismiss(dismiss), .seg(seg), .digit_en(digit_en), .alarm_active(alarm_active));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    t_edges = 0; in_alarm = 0; elapsed = 0;
    exp_seg = 7'b0; exp_de = 4'b0001; exp_aa = 1'b0;
  endtask

  task automatic model_edge();
    int id;
    id = (t_edges / SCAN_DIV) % 4;
    t_edges++;
    if (!in_alarm) begin
      if (alarm_req && !dismiss) begin
        in_alarm = 1; elapsed = 0;
      end
    end else if (dismiss) begin
      in_alarm = 0;
    end else if (alarm_req) begin
      elapsed = 0;
    end else begin
      elapsed++;
      if (elapsed >= ALARM_LEN) in_alarm = 0;
    end
    exp_de = 4'b0001 << id;
    exp_aa = in_alarm;
    if (!in_alarm)                           exp_seg = time_segs[7*id +: 7];
    else if (((elapsed / BLINK_DIV) % 2) == 0) exp_seg = (id % 2 == 1) ? 7'b0111110 : 7'b1100111;
    else                                     exp_seg = 7'b0000000;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".seg"}, {25'd0, seg}, {25'd0, exp_seg});
    check({tag, ".digit_en"}, {28'd0, digit_en}, {28'd0, exp_de});
    check({tag, ".alarm_active"}, {31'd0, alarm_active}, {31'd0, exp_aa});
  endtask

  // called at a negedge: drive inputs, predict the next edge, compare at the following negedge
  task automatic step(input string tag, input logic req, input logic dis);
    alarm_req = req;
    dismiss = dis;
    model_edge();
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("reset");
    reset = 1'b0;

    for (int i = 0; i < 20; i++) step("scan", 0, 0);

    step("alarm_entry", 1, 0);
    for (int i = 0; i < ALARM_LEN + 6; i++) step("timeout", 0, 0);

    step("dis_entry", 1, 0);
    for (int i = 0; i < 19; i++) step("dis_run", 0, 0);
    step("dismiss", 0, 1);
    for (int i = 0; i < 5; i++) step("after_dis", 0, 0);

    step("restart_entry", 1, 0);
    for (int i = 0; i < 49; i++) step("restart_run", 0, 0);
    step("restart_req", 1, 0);
    for (int i = 0; i < ALARM_LEN + 4; i++) step("restart_tail", 0, 0);

    step("req_and_dis", 1, 1);
    for (int i = 0; i < 4; i++) step("req_and_dis_after", 0, 0);

    // async reset in the blank half of the blink, between edges
    step("pre_rst_entry", 1, 0);
    for (int i = 0; i < BLINK_DIV + 2; i++) step("pre_rst_run", 0, 0);
    check("pre_rst_in_off", {31'd0, alarm_active}, 32'd1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    check_outputs("rst_held");
    reset = 1'b0;

    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(15) == 0) time_segs = 28'($urandom);
      step("rand", ($urandom_range(39) == 0), ($urandom_range(59) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
